// File: rtl/riscv_mc_control.sv
// Multi-cycle control sequencer for the RISC-V datapath: fetch/decode/execute/memory/write-back
// with a data-memory ready handshake, retired-instruction counter and a sticky illegal-opcode trap.
module riscv_mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [3:0]  ALUop,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        trap,
  output logic [3:0]  state,
  output logic [63:0] instret
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WB = 4'd6,
    MEM_WR = 4'd7,
    BRANCH = 4'd8,
    ALU_WB = 4'd9,
    TRAP   = 4'd10
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  state_t      state_q;
  state_t      dec_state;
  logic [3:0]  alu_q;
  logic [3:0]  dec_alu;
  logic        imm_q;
  logic        load_q;
  logic        retire;
  logic [63:0] instret_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dec_state = TRAP;
    dec_alu   = alu_q;
    case (opcode)
      OP_R, OP_I: begin
        if (funct3 == 3'b000) begin
          dec_state = (opcode == OP_R) ? EXEC_R : EXEC_I;
          dec_alu   = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
        end else if (funct3 == 3'b111) begin
          dec_state = (opcode == OP_R) ? EXEC_R : EXEC_I;
          dec_alu   = ALU_AND;
        end else if (funct3 == 3'b110) begin
          dec_state = (opcode == OP_R) ? EXEC_R : EXEC_I;
          dec_alu   = ALU_OR;
        end
      end
      OP_LOAD, OP_STORE: begin
        dec_state = ADDR;
        dec_alu   = ALU_ADD;
      end
      OP_BR: begin
        if (funct3 == 3'b000) begin
          dec_state = BRANCH;
          dec_alu   = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  assign retire = (state_q == ALU_WB) || (state_q == MEM_WB) || (state_q == BRANCH) ||
                  (state_q == MEM_WR && mem_ready);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      alu_q     <= ALU_AND;
      imm_q     <= 1'b0;
      load_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      if (retire) instret_q <= instret_q + 64'd1;
      case (state_q)
        FETCH:  state_q <= DECODE;
        DECODE: begin
          state_q <= dec_state;
          alu_q   <= dec_alu;
          imm_q   <= (opcode == OP_I);
          load_q  <= (opcode == OP_LOAD);
        end
        EXEC_R, EXEC_I:         state_q <= ALU_WB;
        ADDR:                   state_q <= load_q ? MEM_RD : MEM_WR;
        MEM_RD:                 if (mem_ready) state_q <= MEM_WB;
        MEM_WR:                 if (mem_ready) state_q <= FETCH;
        ALU_WB, MEM_WB, BRANCH: state_q <= FETCH;
        TRAP:                   state_q <= TRAP;
        default:                state_q <= TRAP;
      endcase
    end
  end

  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    trap     = 1'b0;
    case (state_q)
      FETCH:  IRWrite = 1'b1;
      EXEC_I: ALUSrc  = 1'b1;
      ADDR:   ALUSrc  = 1'b1;
      ALU_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        ALUSrc   = imm_q;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        ALUSrc  = 1'b1;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        PCWrite  = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        ALUSrc   = 1'b1;
        PCWrite  = mem_ready;
      end
      BRANCH: begin
        PCWrite = 1'b1;
        PCSrc   = zero;
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

  assign ALUop   = alu_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Self-checking bench for riscv_mc_control: a cycle-by-cycle vector table for a short program,
// then hand-written sequences for memory waits, the trap state and reset during a store wait.
module tb_riscv_mc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        zero;
  logic        mem_ready;
  logic        IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc;
  logic [3:0]  ALUop;
  logic        MemRead, MemWrite, MemtoReg, trap;
  logic [3:0]  state;
  logic [63:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  riscv_mc_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUop(ALUop), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .trap(trap), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [7:0]  ctrl;   // {IRWrite,PCWrite,PCSrc,RegWrite,ALUSrc,MemRead,MemWrite,MemtoReg}
    logic [3:0]  alu;
    logic [63:0] inst;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic logic [7:0] ctrl_bits();
    return {IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input logic rdy);
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // add, sub, ori, beq taken, beq not taken, store, and, then next fetch
    tbl[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b1, 1'b0, 4'd0, 8'h80, 4'h0, 64'd0};
    tbl[1]  = '{7'b0110011, 3'b000, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00, 4'h0, 64'd0};
    tbl[2]  = '{7'b0110011, 3'b000, 1'b0, 1'b1, 1'b0, 4'd2, 8'h00, 4'h2, 64'd0};
    tbl[3]  = '{7'b0110011, 3'b000, 1'b0, 1'b1, 1'b0, 4'd9, 8'h50, 4'h2, 64'd0};
    tbl[4]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1, 4'd0, 8'h80, 4'h2, 64'd1};
    tbl[5]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1, 4'd1, 8'h00, 4'h2, 64'd1};
    tbl[6]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1, 4'd2, 8'h00, 4'h6, 64'd1};
    tbl[7]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1, 4'd9, 8'h50, 4'h6, 64'd1};
    tbl[8]  = '{7'b0010011, 3'b110, 1'b0, 1'b1, 1'b0, 4'd0, 8'h80, 4'h6, 64'd2};
    tbl[9]  = '{7'b0010011, 3'b110, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00, 4'h6, 64'd2};
    tbl[10] = '{7'b0010011, 3'b110, 1'b0, 1'b1, 1'b0, 4'd3, 8'h08, 4'h1, 64'd2};
    tbl[11] = '{7'b0010011, 3'b110, 1'b0, 1'b1, 1'b0, 4'd9, 8'h58, 4'h1, 64'd2};
    tbl[12] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 4'd0, 8'h80, 4'h1, 64'd3};
    tbl[13] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00, 4'h1, 64'd3};
    tbl[14] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 4'd8, 8'h60, 4'h6, 64'd3};
    tbl[15] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 4'd0, 8'h80, 4'h6, 64'd4};
    tbl[16] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 4'd1, 8'h00, 4'h6, 64'd4};
    tbl[17] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 4'd8, 8'h40, 4'h6, 64'd4};
    tbl[18] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, 4'd0, 8'h80, 4'h6, 64'd5};
    tbl[19] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, 4'd1, 8'h00, 4'h6, 64'd5};
    tbl[20] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, 4'd4, 8'h08, 4'h2, 64'd5};
    tbl[21] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, 4'd7, 8'h4A, 4'h2, 64'd5};
    tbl[22] = '{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0, 8'h80, 4'h2, 64'd6};
    tbl[23] = '{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 4'd1, 8'h00, 4'h2, 64'd6};
    tbl[24] = '{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 4'd2, 8'h00, 4'h0, 64'd6};
    tbl[25] = '{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 4'd9, 8'h50, 4'h0, 64'd6};
    tbl[26] = '{7'b0110011, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0, 8'h80, 4'h0, 64'd7};

    reset = 1'b1;
    apply(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    do_reset();
    check("reset_state", 64'(state), 64'd0);
    check("reset_ctrl", 64'(ctrl_bits()), 64'h80);
    check("reset_aluop", 64'(ALUop), 64'h0);
    check("reset_trap", 64'(trap), 64'd0);
    check("reset_instret", instret, 64'd0);

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].rdy);
      check($sformatf("vec%0d_state", i), 64'(state), 64'(tbl[i].st));
      check($sformatf("vec%0d_ctrl", i), 64'(ctrl_bits()), 64'(tbl[i].ctrl));
      check($sformatf("vec%0d_aluop", i), 64'(ALUop), 64'(tbl[i].alu));
      check($sformatf("vec%0d_instret", i), instret, tbl[i].inst);
      check($sformatf("vec%0d_rd_wr_excl", i), 64'(MemRead & MemWrite), 64'd0);
      tick();
    end

    // Load with three wait cycles: FETCH, DECODE, ADDR, 4x MEM_RD, MEM_WB
    do_reset();
    apply(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    check("ld_fetch", 64'(state), 64'd0);
    tick();
    check("ld_decode", 64'(state), 64'd1);
    tick();
    check("ld_addr", 64'(state), 64'd4);
    check("ld_addr_alusrc", 64'(ALUSrc), 64'd1);
    check("ld_addr_aluop", 64'(ALUop), 64'h2);
    tick();
    for (int w = 0; w < 4; w++) begin
      if (w == 3) apply(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
      check($sformatf("ld_wait%0d_state", w), 64'(state), 64'd5);
      check($sformatf("ld_wait%0d_ctrl", w), 64'(ctrl_bits()), 64'h0C);
      tick();
    end
    apply(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
    check("ld_wb_state", 64'(state), 64'd6);
    check("ld_wb_ctrl", 64'(ctrl_bits()), 64'h51);
    check("ld_wb_instret", instret, 64'd0);
    tick();
    check("ld_done_state", 64'(state), 64'd0);
    check("ld_done_instret", instret, 64'd1);

    // Illegal opcode: absorbing TRAP, only reset leaves it
    do_reset();
    apply(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
    tick();
    check("trap_decode", 64'(state), 64'd1);
    tick();
    for (int c = 0; c < 20; c++) begin
      check($sformatf("trap%0d_state", c), 64'(state), 64'd10);
      check($sformatf("trap%0d_flag", c), 64'(trap), 64'd1);
      check($sformatf("trap%0d_ctrl", c), 64'(ctrl_bits()), 64'h00);
      check($sformatf("trap%0d_instret", c), instret, 64'd0);
      tick();
    end
    do_reset();
    check("trap_reset_state", 64'(state), 64'd0);
    check("trap_reset_flag", 64'(trap), 64'd0);

    // Unsupported funct3 on an R-type also traps
    apply(7'b0110011, 3'b001, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("badfunct_state", 64'(state), 64'd10);
    check("badfunct_trap", 64'(trap), 64'd1);

    // Reset during a store wait wins over a simultaneous mem_ready
    do_reset();
    apply(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    check("st_wait_state", 64'(state), 64'd7);
    check("st_wait_ctrl", 64'(ctrl_bits()), 64'h0A);
    tick();
    check("st_wait2_ctrl", 64'(ctrl_bits()), 64'h0A);
    apply(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
    do_reset();
    apply(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
    check("st_rst_state", 64'(state), 64'd0);
    check("st_rst_memwrite", 64'(MemWrite), 64'd0);
    check("st_rst_instret", instret, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
